// File: rtl/seq_shift_add_mul.sv
// Iterative shift-add multiplier, WIDTH-bit signed/unsigned operands, valid/ready in and out.
// Optional early termination when no multiplier bits remain: define MUL_EARLY_TERM_EN.
module seq_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mult;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_sum;

  // The most-negative operand negates to itself, which is the correct unsigned magnitude.
  assign w_a_mag   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_b_mag   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_acc_sum = r_mult[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MUL_EARLY_TERM_EN
  assign w_last = (r_cnt == LAST_CNT) || ((r_mult >> 1) == '0);
`else
  assign w_last = (r_cnt == LAST_CNT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_RUN;
      S_RUN:  if (w_last) w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mult    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
            r_mult  <= w_b_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_sum;
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= r_neg ? (~w_acc_sum + (2*WIDTH)'(1)) : w_acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign product   = r_product;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed-vector bench for seq_shift_add_mul at WIDTH=8; honours MUL_EARLY_TERM_EN for latency.
module tb_seq_shift_add_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_shift_add_mul #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int NV = 12;
  logic [7:0]  va [NV] = '{8'd15, 8'd255, 8'h80, 8'hFD, 8'd5, 8'h80, 8'd127, 8'hFD, 8'hFD, 8'h5A, 8'h5A, 8'h5A};
  logic [7:0]  vb [NV] = '{8'd13, 8'd255, 8'h80, 8'd7,  8'd0, 8'd2,  8'h80,  8'd3,  8'd3,  8'd1,  8'h10, 8'h80};
  logic        vs [NV] = '{1'b0,  1'b0,   1'b1,  1'b1,  1'b1, 1'b0,  1'b1,   1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
  logic [15:0] vp [NV] = '{16'd195, 16'hFE01, 16'h4000, 16'hFFEB, 16'h0000, 16'h0100,
                           16'hC080, 16'h02F7, 16'hFFF7, 16'h005A, 16'h05A0, 16'h2D00};

  function automatic int exp_lat(input logic [7:0] bv, input logic s);
`ifdef MUL_EARLY_TERM_EN
    logic [7:0] m;
    int l;
    m = (s && bv[7]) ? 8'(~bv + 8'd1) : bv;
    l = 1;
    for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  // Presents one operand set, returns the product and the edges from accept to out_valid.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                        output logic [15:0] p, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    a = ia; b = ib; is_signed = is; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
  endtask

  task automatic test_products();
    logic [15:0] p;
    int lat;
    for (int i = 0; i < NV; i++) begin
      run_op(va[i], vb[i], vs[i], p, lat);
      n_tests++;
      if (p !== vp[i]) begin
        n_fail++;
        $display("FAIL product_%0d: a=%h b=%h s=%b got %h, required %h", i, va[i], vb[i], vs[i], p, vp[i]);
      end
      n_tests++;
      if (lat !== exp_lat(vb[i], vs[i])) begin
        n_fail++;
        $display("FAIL latency_%0d: a=%h b=%h got %0d edges, required %0d", i, va[i], vb[i], lat, exp_lat(vb[i], vs[i]));
      end
      $display("[TB] op %0d: a=%h b=%h signed=%b product=%h latency=%0d", i, va[i], vb[i], vs[i], p, lat);
    end
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  bad;
    @(negedge clk);
    a = 8'd15; b = 8'd13; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 8'd2; b = 8'd2;  // in_valid stays high with a different operand set
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat !== exp_lat(8'd13, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d edges, required %0d", lat, exp_lat(8'd13, 1'b0));
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (product !== 16'd195 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: product=%h in_ready=%b out_valid=%b, required 00c3 0 1", product, in_ready, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_accept: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (product !== 16'd4 || lat !== exp_lat(8'd2, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_next_op: product=%h lat=%0d, required 0004 %0d", product, lat, exp_lat(8'd2, 1'b0));
    end
    $display("[TB] backpressure: held 20 cycles, next op product=%h latency=%0d", product, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit seen;
    @(negedge clk);
    a = 8'd15; b = 8'd13; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_running: busy=%b out_valid=%b, required 1 0", busy, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0) begin
      n_fail++;
      $display("FAIL midrst_state: in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL midrst_no_result: out_valid/busy rose after abort, required both 0");
    end
    $display("[TB] mid-run reset: aborted, product=%h", product);
  endtask

  initial begin
    test_reset();
    test_products();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
